// File: rtl/bsearch_datapath.sv
// Address/bounds datapath for the binary-search engine: midpoint address generation,
// RAM latency absorption and hit / not-found reporting. Optional BSEARCH_STEP_COUNT_EN adds probe_cnt.
module bsearch_datapath #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reset_bounds,
  input  logic              set_high,
  input  logic              set_low,
  input  logic              found,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] current_data,
  output logic              data_valid,
  output logic [ADDR_W-1:0] result_addr,
  output logic              hit,
  output logic              not_found
`ifdef BSEARCH_STEP_COUNT_EN
  ,
  output logic [$clog2(ADDR_W+2)-1:0] probe_cnt
`endif
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_VALID,
    S_HIT,
    S_EXHAUSTED
  } state_t;

  localparam logic [ADDR_W-1:0] LP_TOP       = '1;
  localparam logic [1:0]        LP_WAIT_INIT = 2'(RD_LAT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_low;
  logic [ADDR_W-1:0]   r_high;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic [ADDR_W-1:0]   r_result;
  logic                r_hit;
  logic                r_not_found;
  logic [1:0]          r_wait;
  logic [ADDR_W:0]     w_sum;
  logic [ADDR_W-1:0]   w_mid;
  logic                w_strobe_conflict;

  // Sum carried in ADDR_W+1 bits so low+high never wraps before the halving.
  assign w_sum             = {1'b0, r_low} + {1'b0, r_high};
  assign w_mid             = w_sum[ADDR_W:1];
  assign w_strobe_conflict = set_high & set_low;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_LOAD;
    else       r_state <= w_next;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives w_next and no latch is inferred.
    w_next = r_state;
    if (reset_bounds) begin
      w_next = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD:  w_next = S_ISSUE;
        S_ISSUE: w_next = S_WAIT;
        S_WAIT:  if (r_wait == 2'd0) w_next = S_VALID;
        S_VALID: begin
          if (found)                  w_next = S_HIT;
          else if (w_strobe_conflict) w_next = S_VALID;
          else if (set_high)          w_next = (r_addr == r_low)  ? S_EXHAUSTED : S_ISSUE;
          else if (set_low)           w_next = (r_addr == r_high) ? S_EXHAUSTED : S_ISSUE;
        end
        default: w_next = r_state;
      endcase
    end
  end

`ifdef BSEARCH_STEP_COUNT_EN
  logic [$clog2(ADDR_W+2)-1:0] r_probe_cnt;

  always_ff @(posedge clk) begin
    if (reset)                                  r_probe_cnt <= '0;
    else if (r_state == S_LOAD)                 r_probe_cnt <= '0;
    else if (!reset_bounds && r_state == S_ISSUE) r_probe_cnt <= r_probe_cnt + 1'b1;
  end

  assign probe_cnt = r_probe_cnt;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_low       <= '0;
      r_high      <= LP_TOP;
      r_addr      <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_hit       <= 1'b0;
      r_not_found <= 1'b0;
      r_wait      <= '0;
    end else begin
      if (r_state == S_LOAD) begin
        r_low  <= '0;
        r_high <= LP_TOP;
      end
      if (reset_bounds) begin
        // Abort: any word still in flight from the RAM is simply never captured.
        r_valid     <= 1'b0;
        r_hit       <= 1'b0;
        r_not_found <= 1'b0;
      end else begin
        case (r_state)
          S_ISSUE: begin
            r_addr  <= w_mid;
            r_valid <= 1'b0;
            r_wait  <= LP_WAIT_INIT;
          end
          S_WAIT: begin
            if (r_wait == 2'd0) begin
              r_data  <= ram_q;
              r_valid <= 1'b1;
            end else begin
              r_wait <= r_wait - 2'd1;
            end
          end
          S_VALID: begin
            if (found) begin
              r_result <= r_addr;
              r_hit    <= 1'b1;
            end else if (!w_strobe_conflict) begin
              // Equality tests stop high from going below 0 and low from passing DEPTH-1.
              if (set_high) begin
                if (r_addr == r_low) r_not_found <= 1'b1;
                else                 r_high      <= r_addr - ADDR_W'(1);
              end else if (set_low) begin
                if (r_addr == r_high) r_not_found <= 1'b1;
                else                  r_low       <= r_addr + ADDR_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign addr         = r_addr;
  assign current_data = r_data;
  assign data_valid   = r_valid;
  assign result_addr  = r_result;
  assign hit          = r_hit;
  assign not_found    = r_not_found;

endmodule
